// File: rtl/qc_encoder_stream.sv
// Streaming frame controller for the QC-LDPC encoder: collects KB info slices, waits for the parity
// block, then emits the NB-slice codeword. Define QC_ENC_LEN_CHECK_EN to enable in_last length checking.
module qc_encoder_stream #(
   parameter int Z  = 27,
   parameter int KB = 18,
   parameter int MB = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [Z-1:0]    in_data,
   input  logic            in_last,
   output logic            enc_valid,
   output logic            enc_first,
   output logic [Z-1:0]    enc_data,
   output logic            enc_abort,
   input  logic            enc_done,
   input  logic [MB*Z-1:0] enc_parity,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [Z-1:0]    out_data,
   output logic            out_last,
   output logic            busy,
   output logic            err_len
);
   localparam int NB = KB + MB;
   localparam int CW = $clog2(NB + 1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_EMIT    = 2'd3;
   localparam logic [CW-1:0] KB_M1  = CW'(KB - 1);
   localparam logic [CW-1:0] NB_M1  = CW'(NB - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KB*Z-1:0]  info_q, info_d;
   logic [MB*Z-1:0]  par_q, par_d;
   logic             in_ready_q, in_ready_d;
   logic             enc_valid_q, enc_valid_d;
   logic             enc_first_q, enc_first_d;
   logic [Z-1:0]     enc_data_q, enc_data_d;
   logic             enc_abort_q, enc_abort_d;
   logic             err_len_q, err_len_d;
   logic             out_valid_q, out_valid_d;
   logic [Z-1:0]     out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;
   logic             accept_s;
   logic             len_err_s;

`ifndef QC_ENC_LEN_CHECK_EN
   logic unused_in_last_s;
   assign unused_in_last_s = in_last;
`endif

   // Slice idx of a concatenated vector; index 0 is the MSB end.
   function automatic logic [Z-1:0] cw_slice(input logic [NB*Z-1:0] cw, input logic [CW-1:0] idx);
      logic [Z-1:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) begin
         if (idx == CW'(i)) r = cw[(NB-i)*Z-1 -: Z];
      end
      return r;
   endfunction

   function automatic logic [KB*Z-1:0] put_info(input logic [KB*Z-1:0] v, input logic [CW-1:0] idx,
                                                 input logic [Z-1:0] s);
      logic [KB*Z-1:0] r;
      r = v;
      for (int i = 0; i < KB; i++) begin
         if (idx == CW'(i)) r[(KB-i)*Z-1 -: Z] = s;
      end
      return r;
   endfunction

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      info_d      = info_q;
      par_d       = par_q;
      enc_valid_d = 1'b0;
      enc_first_d = 1'b0;
      enc_data_d  = enc_data_q;
      enc_abort_d = 1'b0;
      err_len_d   = 1'b0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      accept_s    = in_valid & in_ready_q;
`ifdef QC_ENC_LEN_CHECK_EN
      len_err_s   = accept_s & ((in_last & (cnt_q != KB_M1)) | (~in_last & (cnt_q == KB_M1)));
`else
      len_err_s   = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (accept_s && len_err_s) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               enc_abort_d = 1'b1;
               err_len_d   = 1'b1;
            end else if (accept_s) begin
               info_d      = put_info(info_q, cnt_q, in_data);
               enc_valid_d = 1'b1;
               enc_first_d = (cnt_q == '0);
               enc_data_d  = in_data;
               cnt_d       = cnt_q + CW'(1);
               state_d     = (cnt_q == KB_M1) ? S_WAIT : S_COLLECT;
            end else begin
               state_d     = state_q;
            end
         end
         S_WAIT: begin
            if (enc_done) begin
               par_d       = enc_parity;
               state_d     = S_EMIT;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               out_data_d  = info_q[KB*Z-1 -: Z];
               out_last_d  = (NB_M1 == '0);
            end else begin
               state_d     = S_WAIT;
            end
         end
         S_EMIT: begin
            if (out_ready && cnt_q == NB_M1) begin
               state_d     = S_IDLE;
               cnt_d       = '0;
               out_valid_d = 1'b0;
               out_data_d  = '0;
               out_last_d  = 1'b0;
            end else if (out_ready) begin
               cnt_d       = cnt_q + CW'(1);
               out_data_d  = cw_slice({info_q, par_q}, cnt_q + CW'(1));
               out_last_d  = ((cnt_q + CW'(1)) == NB_M1);
            end else begin
               state_d     = S_EMIT;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase
      in_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
      busy_d     = (state_d != S_IDLE);
   end

   // State, buffers and output registers; reset drops any partial frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         info_q      <= '0;
         par_q       <= '0;
         in_ready_q  <= 1'b0;
         enc_valid_q <= 1'b0;
         enc_first_q <= 1'b0;
         enc_data_q  <= '0;
         enc_abort_q <= 1'b0;
         err_len_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         info_q      <= info_d;
         par_q       <= par_d;
         in_ready_q  <= in_ready_d;
         enc_valid_q <= enc_valid_d;
         enc_first_q <= enc_first_d;
         enc_data_q  <= enc_data_d;
         enc_abort_q <= enc_abort_d;
         err_len_q   <= err_len_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign enc_valid = enc_valid_q;
   assign enc_first = enc_first_q;
   assign enc_data  = enc_data_q;
   assign enc_abort = enc_abort_q;
   assign err_len   = err_len_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_qc_encoder_stream.sv
// Self-checking bench for qc_encoder_stream: table of frames on the default instance plus
// hand-written sequences for reset, length errors and a small Z=5/KB=2/MB=1 instance.
module tb_qc_encoder_stream;
   localparam int Z = 27, KB = 18, MB = 6, NB = KB + MB;
   localparam int ZS = 5, KBS = 2, MBS = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic            in_valid, in_ready, in_last, enc_valid, enc_first, enc_abort, enc_done;
   logic [Z-1:0]    in_data, enc_data, out_data;
   logic [MB*Z-1:0] enc_parity;
   logic            out_valid, out_ready, out_last, busy, err_len;

   logic             s_in_valid, s_in_ready, s_in_last, s_enc_valid, s_enc_first, s_enc_abort, s_enc_done;
   logic [ZS-1:0]    s_in_data, s_enc_data, s_out_data;
   logic [MBS*ZS-1:0] s_enc_parity;
   logic             s_out_valid, s_out_ready, s_out_last, s_busy, s_err_len;

   qc_encoder_stream #(.Z(Z), .KB(KB), .MB(MB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .enc_valid(enc_valid), .enc_first(enc_first), .enc_data(enc_data),
      .enc_abort(enc_abort), .enc_done(enc_done), .enc_parity(enc_parity), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .err_len(err_len));

   qc_encoder_stream #(.Z(ZS), .KB(KBS), .MB(MBS)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .in_last(s_in_last), .enc_valid(s_enc_valid), .enc_first(s_enc_first), .enc_data(s_enc_data),
      .enc_abort(s_enc_abort), .enc_done(s_enc_done), .enc_parity(s_enc_parity),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_last(s_out_last), .busy(s_busy), .err_len(s_err_len));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct { logic [Z-1:0] d; logic f; } fwd_t;
   typedef struct { logic [Z-1:0] d; logic l; } out_t;
   fwd_t fwd_q[$];
   out_t out_q[$];

   bit           mon_en = 1'b0;
   logic         prev_acc = 1'b0, stall_prev = 1'b0, last_prev = 1'b0, stall_l = 1'b0;
   logic [Z-1:0] prev_din = '0, stall_d = '0;
   int           err_pulses = 0, abort_pulses = 0;

   // Negedge monitor: collects forwards/codeword slices and checks cycle-level protocol rules.
   always @(negedge clk) begin
      if (enc_valid) fwd_q.push_back('{enc_data, enc_first});
      if (out_valid && out_ready) out_q.push_back('{out_data, out_last});
      if (err_len) err_pulses++;
      if (enc_abort) abort_pulses++;
      if (mon_en) begin
         chk("enc_lag", enc_valid, prev_acc);
         if (prev_acc) chk("enc_data_lag", enc_data, prev_din);
         if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, stall_d);
            chk("stall_last", out_last, stall_l);
         end
         if (out_valid) chk("in_ready_emit", in_ready, 0);
         if (last_prev) chk("in_ready_reassert", in_ready, 1);
      end
      prev_acc   = in_valid && in_ready;
      prev_din   = in_data;
      stall_prev = out_valid && !out_ready;
      stall_d    = out_data;
      stall_l    = out_last;
      last_prev  = out_valid && out_ready && out_last;
   end

   task automatic send_slice(input logic [Z-1:0] d, input logic last);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && g < 100) begin
         step();
         g++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   typedef struct { logic [Z-1:0] base; logic [MB*Z-1:0] par; bit toggle; int lat; } vec_t;
   vec_t tv[4];

   task automatic run_frame(input vec_t v, input int fi);
      int g;
      logic [MB*Z-1:0] p;
      logic [Z-1:0] e;
      p = v.par;
      fwd_q.delete();
      out_q.delete();
      for (int i = 0; i < KB; i++) send_slice(v.base + Z'(i + 1), i == KB - 1);
      g = 0;
      while (fwd_q.size() < KB && g < 50) begin
         step();
         g++;
      end
      chk($sformatf("f%0d_fwd_count", fi), fwd_q.size(), KB);
      repeat (v.lat) step();
      chk($sformatf("f%0d_no_early_out", fi), out_valid, 0);
      enc_parity = v.par;
      enc_done   = 1'b1;
      out_ready  = 1'b1;
      step();
      enc_done   = 1'b0;
      chk($sformatf("f%0d_first_out_valid", fi), out_valid, 1);
      g = 0;
      while (out_q.size() < NB && g < 200) begin
         out_ready = v.toggle ? ~out_ready : 1'b1;
         step();
         g++;
      end
      out_ready = 1'b1;
      step();
      chk($sformatf("f%0d_out_count", fi), out_q.size(), NB);
      chk($sformatf("f%0d_busy_after", fi), busy, 0);
      for (int i = 0; i < KB; i++) begin
         if (i < fwd_q.size()) begin
            chk($sformatf("f%0d_fwd%0d_data", fi, i), fwd_q[i].d, v.base + Z'(i + 1));
            chk($sformatf("f%0d_fwd%0d_first", fi, i), fwd_q[i].f, i == 0);
         end
      end
      for (int i = 0; i < NB; i++) begin
         if (i < out_q.size()) begin
            e = (i < KB) ? v.base + Z'(i + 1) : p[(MB - (i - KB)) * Z - 1 -: Z];
            chk($sformatf("f%0d_out%0d_data", fi, i), out_q[i].d, e);
            chk($sformatf("f%0d_out%0d_last", fi, i), out_q[i].l, i == NB - 1);
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_enc_valid"}, enc_valid, 0);
      chk({tag, "_enc_first"}, enc_first, 0);
      chk({tag, "_enc_data"}, enc_data, 0);
      chk({tag, "_enc_abort"}, enc_abort, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err_len"}, err_len, 0);
      chk({tag, "_s_in_ready"}, s_in_ready, 0);
      chk({tag, "_s_out_valid"}, s_out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [ZS-1:0] sd0[2], sd1[2], spar[2];

   initial begin
      tv[0] = '{27'd0, {27'h1000001, 27'h1000002, 27'h1000003, 27'h1000004, 27'h1000005, 27'h1000006}, 1'b0, 3};
      tv[1] = '{27'd100, {27'h5555555, 27'h2AAAAAA, 27'h7FFFFFF, 27'h0000000, 27'h1234567, 27'h7654321}, 1'b1, 0};
      tv[2] = '{27'h7FFFF00, {27'h0ABCDEF, 27'h3000000, 27'h0000001, 27'h4444444, 27'h6DB6DB6, 27'h0F0F0F0}, 1'b0, 5};
      tv[3] = '{27'd200, {27'h0000011, 27'h0000022, 27'h0000033, 27'h0000044, 27'h0000055, 27'h0000066}, 1'b0, 1};
      sd0[0] = 5'h03; sd1[0] = 5'h1C; spar[0] = 5'h15;
      sd0[1] = 5'h1F; sd1[1] = 5'h00; spar[1] = 5'h0A;

      rst = 1'b0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; enc_done = 1'b0; enc_parity = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_enc_done = 1'b0; s_enc_parity = '0;
      s_out_ready = 1'b0;
      repeat (3) step();
      chk_reset_outputs("rst");
      rst = 1'b1;
      #1;
      chk("in_ready_at_release", in_ready, 0);
      step();
      chk("in_ready_after_release", in_ready, 1);
      mon_en = 1'b1;

      // Stray enc_done in IDLE must not start an emit.
      enc_done = 1'b1;
      step();
      enc_done = 1'b0;
      step();
      chk("idle_done_ignored_valid", out_valid, 0);
      chk("idle_done_ignored_busy", busy, 0);

      for (int f = 0; f < 3; f++) run_frame(tv[f], f);

      // Reset in the middle of a frame.
      mon_en = 1'b0;
      for (int i = 0; i < 10; i++) send_slice(Z'(27'h3F00000 + i), 1'b0);
      chk("mid_busy", busy, 1);
      rst = 1'b0;
      #2;
      chk_reset_outputs("midrst");
      step();
      rst = 1'b1;
      step();
      chk("midrst_in_ready", in_ready, 1);
      mon_en = 1'b1;
      run_frame(tv[3], 3);

`ifdef QC_ENC_LEN_CHECK_EN
      mon_en = 1'b0;
      err_pulses = 0;
      abort_pulses = 0;
      fwd_q.delete();
      for (int i = 0; i < 6; i++) send_slice(Z'(27'h2000000 + i), i == 5);
      repeat (3) step();
      chk("len_err_pulses", err_pulses, 1);
      chk("len_abort_pulses", abort_pulses, 1);
      chk("len_fwd_suppressed", fwd_q.size(), 5);
      chk("len_no_out", out_valid, 0);
      chk("len_idle", busy, 0);
      chk("len_in_ready", in_ready, 1);
      mon_en = 1'b1;
      run_frame(tv[0], 4);
`else
      chk("no_err_len_pulses", err_pulses, 0);
      chk("no_abort_pulses", abort_pulses, 0);
`endif

      // Small instance: 3-slice codeword, two frames to cover the counter wrap.
      for (int f = 0; f < 2; f++) begin
         chk($sformatf("s%0d_in_ready_idle", f), s_in_ready, 1);
         s_in_valid = 1'b1; s_in_data = sd0[f]; s_in_last = 1'b0;
         step();
         chk($sformatf("s%0d_fwd0_valid", f), s_enc_valid, 1);
         chk($sformatf("s%0d_fwd0_first", f), s_enc_first, 1);
         chk($sformatf("s%0d_fwd0_data", f), s_enc_data, sd0[f]);
         s_in_data = sd1[f]; s_in_last = 1'b1;
         step();
         s_in_valid = 1'b0; s_in_last = 1'b0;
         chk($sformatf("s%0d_fwd1_valid", f), s_enc_valid, 1);
         chk($sformatf("s%0d_fwd1_first", f), s_enc_first, 0);
         chk($sformatf("s%0d_fwd1_data", f), s_enc_data, sd1[f]);
         chk($sformatf("s%0d_in_ready_wait", f), s_in_ready, 0);
         chk($sformatf("s%0d_busy_wait", f), s_busy, 1);
         s_enc_parity = spar[f]; s_enc_done = 1'b1;
         step();
         s_enc_done = 1'b0;
         chk($sformatf("s%0d_o0_valid", f), s_out_valid, 1);
         chk($sformatf("s%0d_o0_data", f), s_out_data, sd0[f]);
         chk($sformatf("s%0d_o0_last", f), s_out_last, 0);
         s_out_ready = 1'b0;
         step();
         chk($sformatf("s%0d_o0_stall", f), s_out_data, sd0[f]);
         s_out_ready = 1'b1;
         step();
         chk($sformatf("s%0d_o1_data", f), s_out_data, sd1[f]);
         chk($sformatf("s%0d_o1_last", f), s_out_last, 0);
         step();
         chk($sformatf("s%0d_o2_data", f), s_out_data, spar[f]);
         chk($sformatf("s%0d_o2_last", f), s_out_last, 1);
         chk($sformatf("s%0d_o2_in_ready", f), s_in_ready, 0);
         step();
         s_out_ready = 1'b0;
         chk($sformatf("s%0d_done_valid", f), s_out_valid, 0);
         chk($sformatf("s%0d_done_in_ready", f), s_in_ready, 1);
         chk($sformatf("s%0d_done_busy", f), s_busy, 0);
      end
      chk("s_err_len", s_err_len, 0);
      chk("s_enc_abort", s_enc_abort, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qc_encoder_stream.md
# qc_encoder_stream

Streaming frame controller for the QC-LDPC encoder path, parametrised in lifting size and base-matrix shape. It accepts information bits as Z-bit slices over a valid/ready handshake and forwards each slice to the parity engine. It collects the engine's parity block, then streams the full codeword (info slices, then parity slices) out as Z-bit slices with backpressure. It sits between the upstream bit source and the downstream modulator/interleaver, replacing the fixed-size, handshake-free top-level encoder wrapper.

## Interface
- Z, 27: lifting size; width of every slice.
- KB, 18: information slices per frame.
- MB, 6: parity slices per frame; NB = KB+MB is derived.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream slice valid.
- in_ready  out  1  block can accept a slice.
- in_data  in  Z  information slice; first slice is the MSB end of the codeword.
- in_last  in  1  marks the final info slice of a frame.
- enc_valid  out  1  slice forwarded to the parity engine.
- enc_first  out  1  qualifies enc_valid on slice 0 of a frame.
- enc_data  out  Z  forwarded slice.
- enc_abort  out  1  one-cycle pulse telling the engine to discard the partial frame.
- enc_done  in  1  parity block ready, sampled only in WAIT.
- enc_parity  in  MB*Z  parity block; bits [MB*Z-1 -: Z] form parity slice 0.
- out_valid  out  1  codeword slice valid.
- out_ready  in  1  downstream accepts the slice.
- out_data  out  Z  codeword slice.
- out_last  out  1  marks codeword slice NB-1.
- busy  out  1  high in COLLECT, WAIT and EMIT.
- err_len  out  1  one-cycle pulse when a frame is dropped for a length error.

## Operation
- States are IDLE, COLLECT, WAIT and EMIT. Buffers: info register KB*Z and parity register MB*Z, single-buffered.
- Slice counter width is $clog2(NB+1). It counts accepted input slices in IDLE/COLLECT and emitted slices in EMIT.
- IDLE: in_ready=1. On accept, store the slice at index 0, set cnt=1, and go to COLLECT (or WAIT if KB==1).
- COLLECT: in_ready=1. Each accept stores the slice at index cnt and increments cnt. The accept with cnt==KB-1 goes to WAIT.
- Every accept produces a registered forward on the next cycle: enc_valid=1, enc_data=slice, enc_first=1 iff it was slice 0.
- WAIT: in_ready=0. When enc_done=1, capture enc_parity and go to EMIT. enc_done in any other state is ignored.
- EMIT: in_ready=0 and out_valid=1.
  - out_data is info slice cnt for cnt<KB, else parity slice cnt-KB.
  - On out_valid&out_ready, cnt increments.
  - out_last=1 when cnt==NB-1. Accepting that slice goes to IDLE and clears cnt.
- out_data, out_last and out_valid hold stable while out_ready=0.
- Reset, including mid-frame, returns to IDLE and discards all buffered data. No enc_abort is issued on reset; the engine shares rst.

## Timing
- Reset values: in_ready=0 while rst is low, then 1 on the first clock after release. out_valid=0, out_data=0, out_last=0, enc_valid=0, enc_first=0, enc_data=0, enc_abort=0, busy=0, err_len=0.
- Input throughput is one slice per cycle. There are no bubbles between frames once the previous EMIT has finished.
- enc_valid lags the corresponding input accept by exactly 1 cycle.
- First out_valid is 1 cycle after enc_done is sampled in WAIT.
- Minimum frame period is KB + engine latency + 1 + NB cycles.
- in_ready deasserts in the cycle after the KB-th accept and reasserts the cycle after the out_last accept.

## Configuration
- QC_ENC_LEN_CHECK_EN defined:
  - in_last is checked on every accept. in_last=1 on slice index <KB-1, or in_last=0 on slice KB-1, is a length error.
  - On a length error: drop the frame, pulse err_len and enc_abort in the next cycle, suppress that slice's enc_valid forward, and return to IDLE.
  - On a length error where in_last=0 at slice KB-1, the following slices start a new frame.
- QC_ENC_LEN_CHECK_EN undefined: in_last is ignored and frames are delimited by count only. err_len and enc_abort are tied 0.

## Test plan
- Defaults (Z=27, KB=18, MB=6), in_valid held high with slices 1..18 and engine done 3 cycles after the last forward -> 18 enc_valid pulses with enc_first only on the first; 24 out slices equal to 1..18 then parity slices 0..5 in order; out_last on the 24th.
- out_ready toggled 1/0 every cycle during EMIT -> no slice lost or duplicated; out_data stable while stalled; in_ready=0 throughout.
- Back-to-back frames with out_ready=1 -> in_ready returns 1 exactly one cycle after the out_last handshake; frame 2 is correct.
- rst asserted after 10 input slices, then a full frame -> all outputs at reset values; next frame is clean with no residue from the first 10 slices.
- With QC_ENC_LEN_CHECK_EN, in_last on slice 5 -> err_len and enc_abort pulse once, no out_valid, back in IDLE; a following good frame encodes correctly.
- Z=5, KB=2, MB=1 -> 3-slice codeword; the counter boundaries hold.
